// File: rtl/add_sub_seq.sv
// add_sub_seq: command sequencer around a single n-bit add/subtract unit.
// Runs ADD, SUB and unsigned shift-add MUL on the shared adder and returns
// a 2n-bit result with a one-cycle done pulse. Requires n >= 2.

// Shared datapath: ctr=0 -> {cout,s} = a + b ; ctr=1 -> {cout,s} = a + ~b + 1
module add_sub #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         ctr,
    output logic [n-1:0] s,
    output logic         cout
);
    logic [n-1:0] b_x;
    logic [n:0]   sum;

    // Conditional inversion of b plus carry-in forms a + b or a - b
    always_comb begin
        b_x = ctr ? ~b : b;
        sum = {1'b0, a} + {1'b0, b_x} + {{n{1'b0}}, ctr};
    end

    assign s    = sum[n-1:0];
    assign cout = sum[n];
endmodule

module add_sub_seq #(
    parameter int n = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*n-1:0] result,
    output logic           cy,
    output logic           err
);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    localparam int            CW       = $clog2(n);
    localparam logic [CW-1:0] LAST_STEP = CW'(n - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [n-1:0]     opa_q;
    logic [n-1:0]     opb_q;
    logic [1:0]       op_q;
    logic [n-1:0]     acc_hi_q;
    logic [n-1:0]     acc_lo_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [2*n-1:0]   result_q;
    logic             cy_q;
    logic             err_q;

    // Adder operands and outputs
    logic [n-1:0]     as_a;
    logic [n-1:0]     as_b;
    logic             as_ctr;
    logic [n-1:0]     as_s;
    logic             as_cout;

    // Next values computed from the adder output
    logic [n:0]       mul_sum;
    logic [n-1:0]     acc_hi_d;
    logic [n-1:0]     acc_lo_d;
    logic [2*n-1:0]   exec_result_d;
    logic             exec_cy_d;

    add_sub #(.n(n)) u_add_sub (
        .a    (as_a),
        .b    (as_b),
        .ctr  (as_ctr),
        .s    (as_s),
        .cout (as_cout)
    );

    // Steer the shared adder: accumulator + multiplicand while multiplying,
    // otherwise the latched operands with ctr taken from the opcode LSB
    always_comb begin
        as_a   = opa_q;
        as_b   = opb_q;
        as_ctr = op_q[0];
        if (state_q == S_MUL) begin
            as_a   = acc_hi_q;
            as_b   = opa_q;
            as_ctr = 1'b0;
        end
    end

    // One shift-add step: add the multiplicand only when the current
    // multiplier bit is set, then shift the (2n+1)-bit {sum, acc_lo} right
    always_comb begin
        mul_sum  = acc_lo_q[0] ? {as_cout, as_s} : {1'b0, acc_hi_q};
        acc_hi_d = mul_sum[n:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[n-1:1]};
    end

    // ADD keeps the carry as result bit n; SUB reports a borrow and keeps
    // only the n-bit two's-complement difference
    always_comb begin
        exec_result_d = {{(n-1){1'b0}}, as_cout, as_s};
        exec_cy_d     = as_cout;
        if (op_q == OP_SUB) begin
            exec_result_d = {{n{1'b0}}, as_s};
            exec_cy_d     = ~as_cout;
        end
    end

    // Control FSM with registered outputs; results change only on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cy_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        opa_q  <= a;
                        opb_q  <= b;
                        op_q   <= op;
                        busy_q <= 1'b1;
                        case (op)
                            OP_ADD, OP_SUB: begin
                                state_q <= S_EXEC;
                            end
                            OP_MUL: begin
                                acc_hi_q <= '0;
                                acc_lo_q <= b;
                                cnt_q    <= '0;
                                state_q  <= S_MUL;
                            end
                            default: begin
                                // Illegal opcode completes immediately with an error flag
                                result_q <= '0;
                                cy_q     <= 1'b0;
                                err_q    <= 1'b1;
                                done_q   <= 1'b1;
                                state_q  <= S_DONE;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    result_q <= exec_result_d;
                    cy_q     <= exec_cy_d;
                    err_q    <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_MUL: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q + CNT_ONE;
                    if (cnt_q == LAST_STEP) begin
                        // Take the product from the post-step value, not the stale registers
                        result_q <= {acc_hi_d, acc_lo_d};
                        cy_q     <= 1'b0;
                        err_q    <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cy     = cy_q;
    assign err    = err_q;
endmodule

// File: tb/tb_add_sub_seq.sv
// Bench for add_sub_seq (n=4): table of directed commands, a few random
// commands against an arithmetic model, plus busy-start and mid-MUL reset.
module tb_add_sub_seq;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [1:0]     op;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] result;
    logic           cy;
    logic           err;

    always #5 clk = ~clk;

    add_sub_seq #(.n(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cy     (cy),
        .err    (err)
    );

    typedef struct {
        logic [1:0]     op;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] res;
        logic           cy;
        logic           err;
        int             lat;
    } vec_t;

    typedef struct {
        logic [2*N-1:0] res;
        logic           cy;
        logic           err;
        int             lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests = tests + 1;
        if (act !== req) begin
            fails = fails + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Independent arithmetic reference; latency counts edges from the accepting edge inclusive
    function automatic exp_t model(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
        exp_t e;
        int   xi = int'(x);
        int   yi = int'(y);
        int   r;
        e.cy  = 1'b0;
        e.err = 1'b0;
        case (o)
            2'b00: begin r = xi + yi; e.res = r[2*N-1:0]; e.cy = (r > 15); e.lat = 2; end
            2'b01: begin r = (xi - yi) & 15; e.res = r[2*N-1:0]; e.cy = (xi < yi); e.lat = 2; end
            2'b10: begin r = xi * yi; e.res = r[2*N-1:0]; e.lat = N + 1; end
            default: begin e.res = '0; e.err = 1'b1; e.lat = 1; end
        endcase
        return e;
    endfunction

    // Call just after a negedge. Issues one command, waits for done, compares.
    task automatic run_cmd(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y, input exp_t e);
        int   edges;
        bit   got;
        exp_t p;
        for (int w = 0; w < 30 && busy === 1'b1; w++) @(negedge clk);
        sb.push_back(e);
        op = o; a = x; b = y; start = 1'b1;
        edges = 0;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
            if (edges == 1) check("busy_after_accept", 32'(busy), 32'd1);
            if (done === 1'b1) got = 1'b1;
        end
        if (!got) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL done_timeout actual=none required=done");
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() > 0) begin
            p = sb.pop_front();
            check("latency", 32'(edges), 32'(p.lat));
            check("result", 32'(result), 32'(p.res));
            check("cy", 32'(cy), 32'(p.cy));
            check("err", 32'(err), 32'(p.err));
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
            check("result_held", 32'(result), 32'(p.res));
        end
    endtask

    initial begin
        exp_t e;
        int   d0;
        logic [1:0]   ro;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        vecs[0] = '{2'b00, 4'hF, 4'h1, 8'h10, 1'b1, 1'b0, 2};
        vecs[1] = '{2'b01, 4'h1, 4'h2, 8'h0F, 1'b1, 1'b0, 2};
        vecs[2] = '{2'b01, 4'h9, 4'h6, 8'h03, 1'b0, 1'b0, 2};
        vecs[3] = '{2'b10, 4'hF, 4'hF, 8'hE1, 1'b0, 1'b0, 5};
        vecs[4] = '{2'b10, 4'h5, 4'hB, 8'h37, 1'b0, 1'b0, 5};
        vecs[5] = '{2'b10, 4'h7, 4'h0, 8'h00, 1'b0, 1'b0, 5};
        vecs[6] = '{2'b11, 4'h3, 4'h4, 8'h00, 1'b0, 1'b1, 1};
        vecs[7] = '{2'b00, 4'h1, 4'h2, 8'h03, 1'b0, 1'b0, 2};
        vecs[8] = '{2'b00, 4'h5, 4'h3, 8'h08, 1'b0, 1'b0, 2};
        vecs[9] = '{2'b01, 4'h5, 4'h5, 8'h00, 1'b0, 1'b0, 2};

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cy", 32'(cy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            e.res = vecs[i].res; e.cy = vecs[i].cy; e.err = vecs[i].err; e.lat = vecs[i].lat;
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, e);
        end

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            run_cmd(ro, ra, rb, model(ro, ra, rb));
        end

        // start held high during MUL must not launch a second command
        d0 = done_cnt;
        op = 2'b10; a = 4'hF; b = 4'hF; start = 1'b1;
        sb.push_back(model(2'b10, 4'hF, 4'hF));
        @(posedge clk);
        @(negedge clk);
        op = 2'b00; a = 4'h1; b = 4'h1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("busy_start_result", 32'(result), 32'(e.res));
        end
        repeat (5) @(negedge clk);
        check("busy_start_one_done", 32'(done_cnt - d0), 32'd1);
        check("busy_start_result_kept", 32'(result), 32'hE1);
        check("busy_start_idle", 32'(busy), 32'd0);

        // reset during MUL step 2 aborts without a done pulse
        d0 = done_cnt;
        op = 2'b10; a = 4'h3; b = 4'h5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);

        // back-to-back commands after reset
        run_cmd(2'b00, 4'h6, 4'h7, model(2'b00, 4'h6, 4'h7));
        run_cmd(2'b01, 4'h2, 4'h7, model(2'b01, 4'h2, 4'h7));
        run_cmd(2'b10, 4'h3, 4'h6, model(2'b10, 4'h3, 4'h6));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
